sdram_whitebox: RTL and testbench

Passive white-box monitor for the Wishbone-to-SDRAM controller. It taps the controller's SDRAM command pins and Wishbone handshake signals. It decodes SDRAM commands and tracks the power-up initialisation sequence. It raises sticky protocol-violation flags that the verification environment and any debug registers can read. It drives no controller signals.

---
 rtl/sdram_whitebox_pkg.sv | 50 +++++
 rtl/sdram_whitebox_if.sv | 27 ++
 rtl/sdram_cmd_decode.sv | 29 ++
 rtl/sdram_whitebox.sv | 182 ++++++++++++++++++
 tb/tb_sdram_whitebox.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_whitebox_pkg.sv
// Shared types for the SDRAM controller white-box monitor:
// command and init-state encodings, error bit indices, MODE fields.
package sdram_whitebox_pkg;

    typedef enum logic [3:0] {
        CMD_NOP          = 4'd0,
        CMD_ACTIVE       = 4'd1,
        CMD_READ         = 4'd2,
        CMD_WRITE        = 4'd3,
        CMD_BURST_TERM   = 4'd4,
        CMD_PRECHARGE    = 4'd5,
        CMD_AUTO_REFRESH = 4'd6,
        CMD_LOAD_MODE    = 4'd7,
        CMD_DESELECT     = 4'd8
    } cmd_e;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        PRE_WAIT = 3'd1,
        AR_WAIT  = 3'd2,
        LMR_WAIT = 3'd3,
        DONE     = 3'd4
    } init_state_e;

    localparam int ERR_W          = 7;
    localparam int ERR_INIT_NOP   = 0;
    localparam int ERR_INIT_ORDER = 1;
    localparam int ERR_CYC_STB    = 2;
    localparam int ERR_ACK        = 3;
    localparam int ERR_RST_REACT  = 4;
    localparam int ERR_MODE       = 5;
    localparam int ERR_CAS_LAT    = 6;

    // MODE register fields on sdr_addr
    localparam int         MODE_BT_BIT  = 3;
    localparam logic [2:0] MODE_BL_FULL = 3'b111;
    localparam logic [2:0] MODE_CL2     = 3'b010;
    localparam logic [2:0] MODE_CL3     = 3'b011;

    // Full-page bursts need the sequential burst type;
    // only CAS latency 2 and 3 are supported.
    function automatic logic mode_valid(logic [6:0] m);
        logic bl_ok;
        logic cl_ok;
        bl_ok = !((m[2:0] == MODE_BL_FULL) && !m[MODE_BT_BIT]);
        cl_ok = (m[6:4] == MODE_CL2) || (m[6:4] == MODE_CL3);
        return bl_ok && cl_ok;
    endfunction

endpackage

// File: rtl/sdram_whitebox_if.sv
// Tap bundle: SDRAM command/address pins, read-valid and the
// Wishbone handshake. master = controller side, slave = monitor.
interface sdram_whitebox_if #(
    parameter int ADDR_W = 13
);
    logic              sdr_cs_n;
    logic              sdr_ras_n;
    logic              sdr_cas_n;
    logic              sdr_we_n;
    logic [ADDR_W-1:0] sdr_addr;
    logic              sdr_dq_vld;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_ack_o;

    modport master (
        output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
        output sdr_addr, sdr_dq_vld,
        output wb_cyc_i, wb_stb_i, wb_ack_o
    );

    modport slave (
        input sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
        input sdr_addr, sdr_dq_vld,
        input wb_cyc_i, wb_stb_i, wb_ack_o
    );
endinterface

// File: rtl/sdram_cmd_decode.sv
// Combinational SDRAM pin decoder.
// Ports: cs_n/ras_n/cas_n/we_n in, cmd (cmd_e) out.
module sdram_cmd_decode
    import sdram_whitebox_pkg::*;
(
    input  logic cs_n,
    input  logic ras_n,
    input  logic cas_n,
    input  logic we_n,
    output cmd_e cmd
);

    always_comb begin
        cmd = CMD_DESELECT;
        if (!cs_n) begin
            unique case ({ras_n, cas_n, we_n})
                3'b111: cmd = CMD_NOP;
                3'b011: cmd = CMD_ACTIVE;
                3'b101: cmd = CMD_READ;
                3'b100: cmd = CMD_WRITE;
                3'b110: cmd = CMD_BURST_TERM;
                3'b010: cmd = CMD_PRECHARGE;
                3'b001: cmd = CMD_AUTO_REFRESH;
                3'b000: cmd = CMD_LOAD_MODE;
            endcase
        end
    end

endmodule

// File: rtl/sdram_whitebox.sv
// Passive monitor of the Wishbone-to-SDRAM controller: decodes
// commands, tracks power-up init, raises sticky protocol flags.
// Ports: clk, rst_n (async low); bus (sdram_whitebox_if.slave);
// cmd, init_state, init_done, cas_lat, err[6:0], ref/rd/wr_cnt.
// Macro WBOX_ASSERT_EN adds SVA assertions/covers on the flags.
module sdram_whitebox
    import sdram_whitebox_pkg::*;
#(
    parameter int INIT_CYCLES = 10000,
    parameter int INIT_AR     = 2,
    parameter int ADDR_W      = 13,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sdram_whitebox_if.slave      bus,
    output logic [3:0]           cmd,
    output logic [2:0]           init_state,
    output logic                 init_done,
    output logic [1:0]           cas_lat,
    output logic [ERR_W-1:0]     err,
    output logic [CNT_W-1:0]     ref_cnt,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [CNT_W-1:0]     wr_cnt
);

    localparam int PWR_W = $clog2(INIT_CYCLES + 1);
    localparam int AR_W  = $clog2(INIT_AR + 1);

    if (ADDR_W < 7) begin : g_addr_chk
        $error("sdram_whitebox: ADDR_W must be at least 7");
    end

    cmd_e              dec;
    init_state_e       state;
    init_state_e       state_nxt;
    logic [PWR_W-1:0]  pwr_cnt;
    logic [AR_W-1:0]   ar_cnt;
    logic              pwr_last;
    logic              ar_last;
    logic [2:0]        rd_pipe;
    logic              cas_tag;
    logic              first;
    logic              lmr_ok;
    logic [ERR_W-1:0]  err_set;

    sdram_cmd_decode u_dec (
        .cs_n  (bus.sdr_cs_n),
        .ras_n (bus.sdr_ras_n),
        .cas_n (bus.sdr_cas_n),
        .we_n  (bus.sdr_we_n),
        .cmd   (dec)
    );

    assign pwr_last = (pwr_cnt == PWR_W'(INIT_CYCLES - 1));
    assign ar_last  = (ar_cnt == AR_W'(INIT_AR - 1));
    assign lmr_ok   = mode_valid(bus.sdr_addr[6:0]);

    // rd_pipe[k] marks a READ sampled k+1 clocks ago
    assign cas_tag = (cas_lat == 2'd2) ? rd_pipe[1] : rd_pipe[2];

    // ---- init FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PWR_WAIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            PWR_WAIT: if (pwr_last) state_nxt = PRE_WAIT;
            PRE_WAIT: if (dec == CMD_PRECHARGE) state_nxt = AR_WAIT;
            AR_WAIT:
                if (dec == CMD_AUTO_REFRESH && ar_last)
                    state_nxt = LMR_WAIT;
            LMR_WAIT: if (dec == CMD_LOAD_MODE) state_nxt = DONE;
            default:  state_nxt = DONE;
        endcase
    end

    always_comb begin
        init_state = state;
        init_done  = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_cnt <= '0;
            ar_cnt  <= '0;
        end else begin
            if (state == PWR_WAIT && !pwr_last)
                pwr_cnt <= pwr_cnt + PWR_W'(1);
            if (state == AR_WAIT && dec == CMD_AUTO_REFRESH)
                ar_cnt <= ar_cnt + AR_W'(1);
        end
    end

    // ---- violation detection ----
    always_comb begin
        err_set = '0;
        err_set[ERR_INIT_NOP] = (state == PWR_WAIT)
            && (dec != CMD_NOP) && (dec != CMD_DESELECT);
        err_set[ERR_INIT_ORDER] = (state != PWR_WAIT)
            && (state != DONE)
            && (dec inside {CMD_READ, CMD_WRITE, CMD_ACTIVE});
        err_set[ERR_CYC_STB] = bus.wb_stb_i && !bus.wb_cyc_i;
        err_set[ERR_ACK] = bus.wb_ack_o
            && !(bus.wb_cyc_i && bus.wb_stb_i);
        err_set[ERR_RST_REACT] = first
            && (bus.wb_stb_i || bus.wb_ack_o);
        err_set[ERR_MODE] = (dec == CMD_LOAD_MODE) && !lmr_ok;
        err_set[ERR_CAS_LAT] = cas_tag && !bus.sdr_dq_vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= CMD_NOP;
            err     <= '0;
            cas_lat <= 2'd3;
            rd_pipe <= '0;
            first   <= 1'b1;
        end else begin
            cmd     <= dec;
            err     <= err | err_set;
            rd_pipe <= {rd_pipe[1:0], dec == CMD_READ};
            first   <= 1'b0;
            if (dec == CMD_LOAD_MODE && lmr_ok)
                cas_lat <= bus.sdr_addr[5:4];
        end
    end

    // ---- saturating event counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
        end else begin
            if (dec == CMD_AUTO_REFRESH && !(&ref_cnt))
                ref_cnt <= ref_cnt + CNT_W'(1);
            if (dec == CMD_READ && !(&rd_cnt))
                rd_cnt <= rd_cnt + CNT_W'(1);
            if (dec == CMD_WRITE && !(&wr_cnt))
                wr_cnt <= wr_cnt + CNT_W'(1);
        end
    end

`ifdef WBOX_ASSERT_EN
    a_init_nop: assert property (@(posedge clk) disable iff (!rst_n)
        !err_set[ERR_INIT_NOP]) else $error("INIT_NOP");
    a_init_order: assert property (@(posedge clk) disable iff (!rst_n)
        !err_set[ERR_INIT_ORDER]) else $error("INIT_ORDER");
    a_cyc_stb: assert property (@(posedge clk) disable iff (!rst_n)
        !err_set[ERR_CYC_STB]) else $error("CYC_STB");
    a_ack: assert property (@(posedge clk) disable iff (!rst_n)
        !err_set[ERR_ACK]) else $error("ACK");
    a_rst_react: assert property (@(posedge clk) disable iff (!rst_n)
        !err_set[ERR_RST_REACT]) else $error("RST_REACT");
    a_mode: assert property (@(posedge clk) disable iff (!rst_n)
        !err_set[ERR_MODE]) else $error("MODE");
    a_cas_lat: assert property (@(posedge clk) disable iff (!rst_n)
        !err_set[ERR_CAS_LAT]) else $error("CAS_LAT");

    c_init_nop: cover property (@(posedge clk) disable iff (!rst_n)
        err_set[ERR_INIT_NOP]);
    c_init_order: cover property (@(posedge clk) disable iff (!rst_n)
        err_set[ERR_INIT_ORDER]);
    c_cyc_stb: cover property (@(posedge clk) disable iff (!rst_n)
        err_set[ERR_CYC_STB]);
    c_ack: cover property (@(posedge clk) disable iff (!rst_n)
        err_set[ERR_ACK]);
    c_rst_react: cover property (@(posedge clk) disable iff (!rst_n)
        err_set[ERR_RST_REACT]);
    c_mode: cover property (@(posedge clk) disable iff (!rst_n)
        err_set[ERR_MODE]);
    c_cas_lat: cover property (@(posedge clk) disable iff (!rst_n)
        err_set[ERR_CAS_LAT]);
`else
    // flags only
`endif

endmodule

// File: tb/tb_sdram_whitebox.sv
// Self-checking bench for sdram_whitebox: directed init/error
// scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_sdram_whitebox;
    import sdram_whitebox_pkg::*;

    localparam int INIT_CYCLES = 10000;
    localparam int INIT_AR     = 2;
    localparam int CNT_W       = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       cmd;
    logic [2:0]       init_state;
    logic             init_done;
    logic [1:0]       cas_lat;
    logic [6:0]       err;
    logic [CNT_W-1:0] ref_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    always #5 clk = ~clk;

    sdram_whitebox_if #(.ADDR_W(13)) bus ();

    sdram_whitebox #(
        .INIT_CYCLES (INIT_CYCLES),
        .INIT_AR     (INIT_AR),
        .ADDR_W      (13),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cmd        (cmd),
        .init_state (init_state),
        .init_done  (init_done),
        .cas_lat    (cas_lat),
        .err        (err),
        .ref_cnt    (ref_cnt),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    int         m_cyc;
    int         m_ar;
    int         m_cas;
    int         m_ref;
    int         m_rd;
    int         m_wr;
    int         m_cmd;
    bit         m_pre;
    bit         m_lmr;
    logic [6:0] m_err;
    int         rd_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pat(input int c);
        case (c)
            0:       return 4'b0111;
            1:       return 4'b0011;
            2:       return 4'b0101;
            3:       return 4'b0100;
            4:       return 4'b0110;
            5:       return 4'b0010;
            6:       return 4'b0001;
            7:       return 4'b0000;
            default: return {1'b1, 3'($urandom)};
        endcase
    endfunction

    function automatic int decode(input logic [3:0] p);
        if (p[3]) return 8;
        for (int i = 0; i < 8; i++)
            if (pat(i) == p) return i;
        return -1;
    endfunction

    // init progress as derived from the command history
    function automatic int m_state();
        if (m_cyc < INIT_CYCLES) return 0;
        if (!m_pre)              return 1;
        if (m_ar < INIT_AR)      return 2;
        if (!m_lmr)              return 3;
        return 4;
    endfunction

    task automatic m_reset();
        m_cyc = 0; m_ar = 0; m_cas = 3;
        m_ref = 0; m_rd = 0; m_wr = 0; m_cmd = 0;
        m_pre = 0; m_lmr = 0; m_err = '0;
        rd_q.delete();
    endtask

    task automatic m_edge(input logic [3:0] p, input logic [12:0] a,
                          input bit vld, cyc, stb, ack);
        int  c, st, e, cl;
        bit  ok;
        c  = decode(p);
        st = m_state();
        e  = m_cyc + 1;
        cl = int'(a[6:4]);
        ok = (cl == 2 || cl == 3) && !(a[2:0] == 3'b111 && !a[3]);
        if (st == 0 && c != 0 && c != 8) m_err[0] = 1'b1;
        if (st != 0 && st != 4 && (c == 1 || c == 2 || c == 3))
            m_err[1] = 1'b1;
        if (stb && !cyc) m_err[2] = 1'b1;
        if (ack && !(cyc && stb)) m_err[3] = 1'b1;
        if (e == 1 && (stb || ack)) m_err[4] = 1'b1;
        if (c == 7 && !ok) m_err[5] = 1'b1;
        foreach (rd_q[i])
            if (e - rd_q[i] == m_cas && !vld) m_err[6] = 1'b1;
        if (c == 7 && ok) m_cas = cl;
        if (c == 2) rd_q.push_back(e);
        while (rd_q.size() > 0 && e - rd_q[0] >= 3) void'(rd_q.pop_front());
        if (c == 6 && m_ref < CNT_MAX) m_ref++;
        if (c == 2 && m_rd < CNT_MAX) m_rd++;
        if (c == 3 && m_wr < CNT_MAX) m_wr++;
        if (st == 1 && c == 5) m_pre = 1;
        if (st == 2 && c == 6) m_ar++;
        if (st == 3 && c == 7) m_lmr = 1;
        m_cyc = e;
        m_cmd = c;
    endtask

    task automatic chk_all();
        check("cmd", cmd, m_cmd);
        check("init_state", init_state, m_state());
        check("init_done", init_done, m_state() == 4);
        check("cas_lat", cas_lat, m_cas);
        check("err", err, m_err);
        check("ref_cnt", ref_cnt, m_ref);
        check("rd_cnt", rd_cnt, m_rd);
        check("wr_cnt", wr_cnt, m_wr);
    endtask

    task automatic drive(input logic [3:0] p, input logic [12:0] a,
                         input bit vld, cyc, stb, ack);
        {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = p;
        bus.sdr_addr   = a;
        bus.sdr_dq_vld = vld;
        bus.wb_cyc_i   = cyc;
        bus.wb_stb_i   = stb;
        bus.wb_ack_o   = ack;
    endtask

    task automatic step(input int c, input logic [12:0] a,
                        input bit vld, cyc, stb, ack, chk);
        logic [3:0] p;
        p = pat(c);
        drive(p, a, vld, cyc, stb, ack);
        @(posedge clk);
        m_edge(p, a, vld, cyc, stb, ack);
        #1;
        if (chk) chk_all();
    endtask

    task automatic cs(input int c, input logic [12:0] a = '0,
                      input bit vld = 1'b0);
        step(c, a, vld, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // asserted asynchronously, released at a falling edge
    task automatic do_reset();
        rst_n = 1'b0;
        drive(pat(0), '0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_reset();
        #1;
        chk_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(pat(0), '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // clean init, CAS checks, MODE checks, Wishbone checks
        do_reset();
        for (int i = 0; i < INIT_CYCLES; i++)
            step(0, '0, 1'b0, 1'b0, 1'b0, 1'b0,
                 (i % 1000 == 999) || (i >= INIT_CYCLES - 2));
        cs(5);
        cs(6);
        cs(6);
        cs(7, 13'h020);
        check("init_done_seq", init_done, 1);
        check("cas_lat_cl2", cas_lat, 2);
        check("err_clean", err, 0);
        check("ref_cnt_init", ref_cnt, 2);
        cs(2);
        cs(0);
        cs(0, '0, 1'b1);
        check("cl2_ok", err[6], 0);
        check("rd_cnt_one", rd_cnt, 1);
        cs(2);
        cs(0);
        cs(0);
        cs(0, '0, 1'b1);
        check("cl2_late", err[6], 1);
        cs(7, 13'h037);
        check("mode_bad", err[5], 1);
        check("mode_bad_cas", cas_lat, 2);
        cs(7, 13'h03F);
        check("mode_cl3", cas_lat, 3);
        cs(3);
        cs(1);
        cs(4);
        check("wr_cnt_one", wr_cnt, 1);
        step(0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("cyc_stb", err[2], 1);
        step(0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("ack_no_stb", err[3], 1);

        // early READ during power-up wait, then async reset in AR_WAIT
        do_reset();
        for (int i = 1; i <= INIT_CYCLES; i++) begin
            step((i == 500) ? 2 : 0, '0, 1'b0, 1'b0, 1'b0, 1'b0,
                 (i >= 498 && i <= 503) || (i % 1000 == 0));
            if (i == 499) check("err0_pre", err[0], 0);
            if (i == 500) check("err0_set", err[0], 1);
        end
        cs(5);
        cs(6);
        check("in_ar_wait", init_state, 2);
        check("err0_sticky", err[0], 1);
        do_reset();
        check("async_err", err, 0);
        check("async_state", init_state, 0);
        check("async_cas", cas_lat, 3);
        step(0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rst_react", err[4], 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < INIT_CYCLES + 3000; i++) begin
            int         r;
            int         c;
            logic [12:0] a;
            bit         cyc;
            bit         stb;
            bit         ack;
            bit         vld;
            r = $urandom_range(0, 99);
            if (i < INIT_CYCLES) c = (r < 70) ? 0 : 8;
            else if (r < 50) c = 0;
            else if (r < 60) c = 8;
            else c = $urandom_range(1, 7);
            a = 13'($urandom);
            if (c == 7 && $urandom_range(0, 3) != 0)
                a[6:4] = 3'($urandom_range(2, 3));
            cyc = bit'($urandom_range(0, 1));
            stb = cyc & bit'($urandom_range(0, 1));
            ack = stb & bit'($urandom_range(0, 1));
            if (i >= INIT_CYCLES) begin
                if ($urandom_range(0, 199) == 0) stb = 1'b1;
                if ($urandom_range(0, 199) == 0) ack = 1'b1;
            end
            vld = ($urandom_range(0, 9) != 0);
            step(c, a, vld, cyc, stb, ack,
                 (i >= INIT_CYCLES - 5) || (i % 997 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
